// File: rtl/sel_pipe_mux.sv
// sel_pipe_mux: pipelined NUM_IN:1 bus multiplexer with valid/ready handshakes and a 2-entry skid buffer.
// Optional SEL_PIPE_MUX_SEL_ERR_EN: out-of-range selects are dropped and flagged on a sticky sel_err output.
module sel_pipe_mux #(
   parameter int  BUS_WIDTH = 32,
   parameter int  NUM_IN    = 3,
   localparam int SEL_W     = $clog2(NUM_IN)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_IN*BUS_WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]            in_sel,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        flush,
   output logic [BUS_WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]            out_sel,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [1:0]                  occupancy
`ifdef SEL_PIPE_MUX_SEL_ERR_EN
   ,
   output logic                        sel_err
`endif
);

   localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

   logic [BUS_WIDTH-1:0] mux_data_s;
   logic                 sel_oor_s;
   logic                 accept_s;
   logic                 enq_s;
   logic                 o_xfer_s;

   logic                 o_valid_q, o_valid_d;
   logic [BUS_WIDTH-1:0] o_data_q,  o_data_d;
   logic [SEL_W-1:0]     o_sel_q,   o_sel_d;
   logic                 s_valid_q, s_valid_d;
   logic [BUS_WIDTH-1:0] s_data_q,  s_data_d;
   logic [SEL_W-1:0]     s_sel_q,   s_sel_d;

   // Channel select; a select with no matching channel leaves the data at zero.
   always_comb begin
      mux_data_s = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (in_sel == SEL_W'(k)) begin
            mux_data_s = in_data[k*BUS_WIDTH +: BUS_WIDTH];
         end else begin
            mux_data_s = mux_data_s;
         end
      end
   end

   assign sel_oor_s = ({1'b0, in_sel} >= NUM_IN_W);
   assign in_ready  = !s_valid_q && !rst;
   assign accept_s  = in_valid && in_ready;
   assign o_xfer_s  = o_valid_q && out_ready;

`ifdef SEL_PIPE_MUX_SEL_ERR_EN
   assign enq_s = accept_s && !sel_oor_s;
`else
   assign enq_s = accept_s;
`endif

   // Next state of the output and skid registers; the skid only fills while the output stalls.
   always_comb begin
      o_valid_d = o_valid_q;
      o_data_d  = o_data_q;
      o_sel_d   = o_sel_q;
      s_valid_d = s_valid_q;
      s_data_d  = s_data_q;
      s_sel_d   = s_sel_q;
      if (flush) begin
         o_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end else if (!o_valid_q || o_xfer_s) begin
         if (s_valid_q) begin
            o_valid_d = 1'b1;
            o_data_d  = s_data_q;
            o_sel_d   = s_sel_q;
            s_valid_d = 1'b0;
         end else if (enq_s) begin
            o_valid_d = 1'b1;
            o_data_d  = mux_data_s;
            o_sel_d   = in_sel;
         end else begin
            o_valid_d = 1'b0;
         end
      end else begin
         if (enq_s) begin
            s_valid_d = 1'b1;
            s_data_d  = mux_data_s;
            s_sel_d   = in_sel;
         end else begin
            s_valid_d = s_valid_q;
         end
      end
   end

   // Storage registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
         o_sel_q   <= '0;
         s_valid_q <= 1'b0;
         s_data_q  <= '0;
         s_sel_q   <= '0;
      end else begin
         o_valid_q <= o_valid_d;
         o_data_q  <= o_data_d;
         o_sel_q   <= o_sel_d;
         s_valid_q <= s_valid_d;
         s_data_q  <= s_data_d;
         s_sel_q   <= s_sel_d;
      end
   end

`ifdef SEL_PIPE_MUX_SEL_ERR_EN
   logic sel_err_q;

   // Sticky flag for dropped out-of-range selects; survives flush, cleared by reset only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_err_q <= 1'b0;
      end else if (accept_s && sel_oor_s) begin
         sel_err_q <= 1'b1;
      end else begin
         sel_err_q <= sel_err_q;
      end
   end

   assign sel_err = sel_err_q;
`endif

   assign out_data  = o_data_q;
   assign out_sel   = o_sel_q;
   assign out_valid = o_valid_q;
   assign occupancy = {1'b0, o_valid_q} + {1'b0, s_valid_q};

endmodule
